store_unit: RTL and testbench
=============================

// Module: store_unit
// PURPOSE
//  Write-side counterpart of the load extension path: takes rs2 data, byte address
//  and func3 of an S-type store (sb/sh/sw/sd) and commits it to the 64-bit
//  doubleword data memory. Sub-doubleword stores run a read-modify-write sequence.
//  Sits between the EX stage and data memory; the control unit stalls while busy=1.
// PARAMETERS
//  MEM_RD_LAT  1   cycles from mem_rd_en to valid mem_rdata (must be >= 1)
//  ADDR_W      64  byte address width
// PORTS
//  clk         in   1       single clock, all state on rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  start       in   1       store request; sampled only in IDLE
//  func3       in   3       000 sb, 001 sh, 010 sw, 011 sd, others illegal
//  addr        in   ADDR_W  byte address (rs1 + imm)
//  wdata       in   64      rs2 value; low bytes used for sb/sh/sw
//  busy        out  1       high from cycle after accepted start until done cycle inclusive
//  done        out  1       one-cycle pulse at end of every accepted request
//  store_err   out  1       valid with done: misaligned or illegal func3
//  mem_addr    out  ADDR_W  {addr[ADDR_W-1:3],3'b000}, held stable while busy
//  mem_rd_en   out  1       one-cycle read strobe
//  mem_rdata   in   64      read data, valid MEM_RD_LAT cycles after mem_rd_en
//  mem_wr_en   out  1       one-cycle write strobe
//  mem_wdata   out  64      full merged doubleword written
//  mem_be      out  8       byte enables of the bytes the store itself changes
// BEHAVIOUR
//  Reset: state IDLE; busy, done, store_err, mem_rd_en, mem_wr_en = 0;
//   mem_addr, mem_wdata, mem_be = 0; latched request and wait counter cleared.
//  Reset mid-operation: the request is aborted immediately (async); no write is issued.
//  States: IDLE, RD, WAIT, WR, DONE.
//  IDLE: start=1 latches func3/addr/wdata; off = addr[2:0].
//   Illegal func3, or misaligned (sh: off[0]!=0; sw: off[1:0]!=0; sd: off!=0)
//     -> DONE with store_err=1, no memory access.
//   sd aligned -> WR (no read). sb/sh/sw aligned -> RD.
//  RD: mem_rd_en=1 for exactly one cycle -> WAIT; counter loads MEM_RD_LAT.
//  WAIT: counter decrements; on the cycle it reaches 1, mem_rdata is captured
//   at the edge -> WR.
//  WR: mem_wr_en=1 one cycle; mem_wdata = captured word with the store bytes
//   replaced, little-endian (byte k = bits 8k+7:8k); mem_be set for the written bytes:
//   sb 1<<off, sh 2'b11<<off, sw 4'hF<<off, sd 8'hFF. Then -> DONE.
//  DONE: done=1 one cycle (store_err as decided) -> IDLE. A new start is
//   accepted in the following IDLE cycle, not during DONE.
//  Latency (start sampled at cycle s): sd done at s+2; sb/sh/sw done at s+MEM_RD_LAT+3;
//   error done at s+1.
//  start while not IDLE is ignored; inputs other than mem_rdata are only sampled at
//   acceptance. mem_addr and mem_be hold stable from RD/WR until IDLE.
//  At most one mem_rd_en and one mem_wr_en per request; never both in one cycle.
// TESTING
//  mem[0x100]=0x1122334455667788, sb addr 0x103 wdata 0xAB
//    -> mem_wdata 0x11223344AB667788, be 0x08, done at s+4 (LAT=1).
//  Same mem, sh addr 0x106 wdata 0xBEEF -> mem_wdata 0xBEEF334455667788, be 0xC0.
//  Same mem, sw addr 0x104 wdata 0xDEADBEEF -> mem_wdata 0xDEADBEEF55667788, be 0xF0.
//  sd addr 0x108 wdata 0x0123456789ABCDEF -> no rd_en, wr_en at s+1 with that data,
//    be 0xFF, done at s+2.
//  sw addr 0x102; then func3=3'b111 -> each: done+store_err at s+1, no rd_en/wr_en.
//  rst_n low during WAIT -> all outputs 0 at once, no wr_en; start pulse during busy
//    ignored; next sb after reset completes normally.

Source files
------------

// File: rtl/store_unit.sv
// Store path to the 64-bit doubleword data memory: sb/sh/sw use a read-modify-write
// sequence, sd writes directly, and illegal or misaligned requests finish with an error.
module store_unit #(
    parameter int MEM_RD_LAT = 1,
    parameter int ADDR_W     = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              store_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [63:0]       mem_rdata,
    output logic              mem_wr_en,
    output logic [63:0]       mem_wdata,
    output logic [7:0]        mem_be
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int CNT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT + 1) : 1;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      data_q;
    logic             err_q;

    logic [2:0]  off;
    logic [7:0]  be_req;
    logic        bad;
    logic [63:0] lane_data;
    logic [63:0] merged;

    assign off       = addr[2:0];
    assign lane_data = wdata << {off, 3'b000};

    always_comb begin
        be_req = 8'h00;
        bad    = 1'b0;
        case (func3)
            3'b000: be_req = 8'h01 << off;
            3'b001: begin
                be_req = 8'h03 << off;
                bad    = off[0];
            end
            3'b010: begin
                be_req = 8'h0F << off;
                bad    = |off[1:0];
            end
            3'b011: begin
                be_req = 8'hFF;
                bad    = |off;
            end
            default: bad = 1'b1;
        endcase
    end

    // Only the byte lanes the store owns come from rs2; the rest keep the read value.
    always_comb begin
        merged = 64'h0;
        for (int k = 0; k < 8; k++) begin
            merged[8*k +: 8] = mem_be[k] ? data_q[8*k +: 8] : mem_rdata[8*k +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            data_q    <= 64'h0;
            err_q     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 64'h0;
            mem_be    <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mem_addr <= {addr[ADDR_W-1:3], 3'b000};
                        data_q   <= lane_data;
                        err_q    <= bad;
                        if (bad) begin
                            mem_be <= 8'h00;
                            state  <= S_DONE;
                        end else begin
                            mem_be <= be_req;
                            if (func3 == 3'b011) begin
                                mem_wdata <= wdata;
                                state     <= S_WR;
                            end else begin
                                state <= S_RD;
                            end
                        end
                    end
                end
                S_RD: begin
                    cnt   <= CNT_W'(MEM_RD_LAT);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        mem_wdata <= merged;
                        state     <= S_WR;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_WR:    state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign store_err = (state == S_DONE) && err_q;
    assign mem_rd_en = (state == S_RD);
    assign mem_wr_en = (state == S_WR);

endmodule

// File: tb/tb_store_unit.sv
// Directed and random stores against a behavioural memory; writes are checked
// through an expected queue, latency and strobe counts per request.
module tb_store_unit;

  localparam int LAT = 1;
  localparam int EW  = 136;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  func3 = 3'b000;
  logic [63:0] addr = 64'h0;
  logic [63:0] wdata = 64'h0;
  logic        busy, done, store_err, mem_rd_en, mem_wr_en;
  logic [63:0] mem_addr, mem_wdata;
  logic [63:0] mem_rdata = 64'h0;
  logic [7:0]  mem_be;

  int tests = 0;
  int fails = 0;
  logic [EW-1:0] exp_q[$];
  logic [63:0] mem[logic [63:0]];

  store_unit #(.MEM_RD_LAT(LAT), .ADDR_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func3(func3), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .store_err(store_err),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .mem_be(mem_be)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Memory responder: data one cycle after the read strobe, filler otherwise.
  always @(posedge clk) begin
    if (mem_rd_en === 1'b1)
      mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 64'h0;
    else
      mem_rdata <= 64'hA5A5_A5A5_A5A5_A5A5;
  end

  // Write monitor: pops the expected queue and commits the write to the model memory.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [63:0] mask;
    if (mem_rd_en === 1'b1 || mem_wr_en === 1'b1)
      chk("rd_wr_exclusive", {135'h0, mem_rd_en & mem_wr_en}, '0);
    if (mem_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {72'h0, mem_addr}, '1);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr_data_be", {mem_addr, mem_wdata, mem_be}, e);
      end
      mask = 64'h0;
      for (int k = 0; k < 8; k++) if (mem_be[k]) mask[8*k +: 8] = 8'hFF;
      mem[mem_addr] = ((mem.exists(mem_addr) ? mem[mem_addr] : 64'h0) & ~mask) | (mem_wdata & mask);
    end
  end

  function automatic int nbytes(input logic [2:0] f);
    case (f)
      3'b000: return 1;
      3'b001: return 2;
      3'b010: return 4;
      3'b011: return 8;
      default: return 0;
    endcase
  endfunction

  task automatic do_store(input logic [2:0] f, input logic [63:0] a, input logic [63:0] d,
                          input bit poke_busy);
    int n, rd_cnt, wr_cnt, wr_at, exp_lat, nb;
    logic exp_err;
    logic [63:0] base, old, res;
    logic [7:0] be;
    bit seen;
    nb = nbytes(f);
    exp_err = (nb == 0) || ((int'(a[2:0]) % nb) != 0);
    base = {a[63:3], 3'b000};
    old = mem.exists(base) ? mem[base] : 64'h0;
    res = old;
    be = 8'h00;
    if (!exp_err) begin
      for (int i = 0; i < nb; i++) begin
        be[int'(a[2:0]) + i] = 1'b1;
        res[8*(int'(a[2:0]) + i) +: 8] = d[8*i +: 8];
      end
      exp_q.push_back({base, res, be});
    end
    exp_lat = exp_err ? 1 : (nb == 8 ? 2 : LAT + 3);
    @(negedge clk);
    start = 1'b1; func3 = f; addr = a; wdata = d;
    @(posedge clk);
    #1;
    start = 1'b0;
    func3 = 3'($urandom_range(0, 7));
    addr = {$urandom, $urandom};
    wdata = {$urandom, $urandom};
    rd_cnt = 0; wr_cnt = 0; wr_at = 0; seen = 0; n = 0;
    while (n < 20 && !seen) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("busy_after_accept", {135'h0, busy}, 1);
      if (poke_busy && n == 2) begin
        start = 1'b1; func3 = 3'b011; addr = 64'h300;
      end
      if (poke_busy && n == 3) start = 1'b0;
      if (mem_rd_en === 1'b1) rd_cnt++;
      if (mem_wr_en === 1'b1) begin wr_cnt++; wr_at = n; end
      if (done === 1'b1) seen = 1;
    end
    start = 1'b0;
    if (!seen) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("done_latency", n, exp_lat);
      chk("store_err", {135'h0, store_err}, {135'h0, exp_err});
      chk("busy_in_done", {135'h0, busy}, 1);
      chk("rd_en_count", rd_cnt, exp_err || nb == 8 ? 0 : 1);
      chk("wr_en_count", wr_cnt, exp_err ? 0 : 1);
      if (!exp_err) chk("wr_en_cycle", wr_at, exp_lat - 1);
      @(negedge clk);
      chk("idle_after_done", {134'h0, busy, done}, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {131'h0, busy, done, store_err, mem_rd_en, mem_wr_en}, 0);
    chk("reset_mem_addr_be", {64'h0, mem_addr, mem_be}, 0);
    chk("reset_mem_wdata", {72'h0, mem_wdata}, 0);
    rst_n = 1'b1;

    mem[64'h100] = 64'h1122334455667788;
    do_store(3'b000, 64'h103, 64'hAB, 0);
    mem[64'h100] = 64'h1122334455667788;
    do_store(3'b001, 64'h106, 64'hBEEF, 0);
    mem[64'h100] = 64'h1122334455667788;
    do_store(3'b010, 64'h104, 64'hDEADBEEF, 0);
    do_store(3'b011, 64'h108, 64'h0123456789ABCDEF, 0);
    do_store(3'b010, 64'h102, 64'hCAFEF00D, 0);
    do_store(3'b111, 64'h100, 64'h55, 0);
    do_store(3'b001, 64'h101, 64'h1234, 0);
    do_store(3'b011, 64'h10C, 64'h1, 0);
    mem[64'h100] = 64'h1122334455667788;
    do_store(3'b000, 64'h107, 64'h77, 1);

    // Abort a read-modify-write while it waits for read data.
    mem[64'h100] = 64'h1122334455667788;
    @(negedge clk);
    start = 1'b1; func3 = 3'b000; addr = 64'h101; wdata = 64'hEE;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ctrl", {131'h0, busy, done, store_err, mem_rd_en, mem_wr_en}, 0);
    chk("abort_mem_addr_be", {64'h0, mem_addr, mem_be}, 0);
    chk("abort_mem_wdata", {72'h0, mem_wdata}, 0);
    start = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_held_ctrl", {133'h0, busy, mem_rd_en, mem_wr_en}, 0);
    start = 1'b0;
    rst_n = 1'b1;
    do_store(3'b000, 64'h105, 64'h99, 0);

    for (int i = 0; i < 8; i++) mem[64'h200 + 64'(8 * i)] = {$urandom, $urandom};
    for (int i = 0; i < 10; i++)
      do_store(3'($urandom_range(0, 4)), 64'h200 + 64'($urandom_range(0, 63)),
               {$urandom, $urandom}, 0);

    repeat (3) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
